// File: rtl/mpe_trace_pkg.sv
// Shared definitions for the 8088 bus cycle tracer: record type codes,
// FSM state encodings and the record width helper.
package mpe_trace_pkg;

  localparam logic [2:0] TR_MEMRD = 3'd0;
  localparam logic [2:0] TR_MEMWR = 3'd1;
  localparam logic [2:0] TR_IORD  = 3'd2;
  localparam logic [2:0] TR_IOWR  = 3'd3;
  localparam logic [2:0] TR_INTA  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  function automatic int unsigned rec_w(input int unsigned addr_w, input int unsigned data_w,
                                        input int unsigned ts_w);
    return 3 + addr_w + data_w + ts_w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Trace buffer: synchronous-read RAM FIFO with clear, and optional
// overwrite-oldest behaviour when full.
module trace_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned WRAP_MODE = 0,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned CW       = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_rvalid,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overwrite
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count, w_count_d;
  logic [WIDTH-1:0] r_rdata;
  logic             r_rvalid;
  logic             w_empty, w_full, w_do_pop, w_do_push, w_ovw;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop & ~w_empty & ~i_clear;
  // A simultaneous pop frees a slot, so push+pop when full is not an overwrite.
  assign w_ovw     = (WRAP_MODE != 0) & i_push & w_full & ~w_do_pop & ~i_clear;
  assign w_do_push = i_push & ~i_clear & (~w_full | w_do_pop | w_ovw);

  always_comb begin
    w_count_d = r_count;
    if (w_do_push && !w_do_pop && !w_ovw) begin
      w_count_d = r_count + CW'(1);
    end else if (w_do_pop && !w_do_push) begin
      w_count_d = r_count - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop || w_ovw) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count  <= w_count_d;
      r_rvalid <= w_do_pop;
      if (w_do_pop) r_rdata <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata     = r_rdata;
  assign o_rvalid    = r_rvalid;
  assign o_count     = r_count;
  assign o_empty     = w_empty;
  assign o_full      = w_full;
  assign o_overwrite = w_ovw;

endmodule

// File: rtl/bus_trace.sv
// Bus cycle tracer: detects command strobe trailing edges, builds timestamped
// records and stores them in a trace FIFO under an arm/trigger FSM.
module bus_trace
  import mpe_trace_pkg::*;
#(
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned TS_W      = 16,
  parameter int unsigned WRAP_MODE = 0,
  localparam int unsigned REC_W    = rec_w(ADDR_W, DATA_W, TS_W),
  localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mrdc_n,
  input  logic              i_mwtc_n,
  input  logic              i_iorc_n,
  input  logic              i_iowc_n,
  input  logic              i_inta_n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_arm,
  input  logic              i_trig_en,
  input  logic [ADDR_W-1:0] i_trig_addr,
  input  logic [ADDR_W-1:0] i_trig_mask,
  input  logic              i_rd_en,
  output logic [REC_W-1:0]  o_rd_data,
  output logic              o_rd_valid,
  output logic              o_empty,
  output logic              o_full,
  output logic [CW-1:0]     o_count,
  output logic              o_triggered,
  output logic              o_overflow,
  output logic              o_collision,
  output logic              o_busy
);

  // Bit index of each strobe equals its record type code.
  logic [4:0]        w_low, r_low, w_end;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rdata, r_wdata, w_data;
  logic [TS_W-1:0]   r_ts;
  logic [2:0]        w_type;
  logic [REC_W-1:0]  w_rec;
  logic              w_event, w_collision, w_trig_hit, w_pop, w_busy;
  logic              w_push, w_set_trig, w_drop_ovf, w_ovw;
  logic              r_triggered, r_overflow, r_collision;
  logic [CW-1:0]     w_count;
  state_e            r_state, w_state_d;

  assign w_low       = ~{i_inta_n, i_iowc_n, i_iorc_n, i_mwtc_n, i_mrdc_n};
  assign w_end       = r_low & ~w_low;
  assign w_event     = |w_end;
  assign w_collision = (w_end & (w_end - 5'd1)) != 5'd0;

  always_comb begin
    w_type = TR_MEMRD;
    if (w_end[4])      w_type = TR_INTA;
    else if (w_end[3]) w_type = TR_IOWR;
    else if (w_end[2]) w_type = TR_IORD;
    else if (w_end[1]) w_type = TR_MEMWR;
  end

  assign w_data     = (w_type == TR_MEMWR || w_type == TR_IOWR) ? r_wdata : r_rdata;
  assign w_rec      = {w_type, r_addr, w_data, r_ts};
  assign w_trig_hit = ((r_addr ^ i_trig_addr) & i_trig_mask) == '0;
  assign w_pop      = i_rd_en & ~i_arm;
  assign w_busy     = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_low   <= '0;
      r_addr  <= '0;
      r_rdata <= '0;
      r_wdata <= '0;
    end else begin
      r_low   <= w_low;
      r_addr  <= i_addr;
      r_rdata <= i_rdata;
      r_wdata <= i_wdata;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_push     = 1'b0;
    w_set_trig = 1'b0;
    w_drop_ovf = 1'b0;
    if (i_arm) begin
      w_state_d = i_trig_en ? ST_ARMED : ST_CAPTURE;
    end else begin
      unique case (r_state)
        ST_ARMED: begin
          if (w_event && w_trig_hit) begin
            w_push     = 1'b1;
            w_set_trig = 1'b1;
            w_state_d  = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (w_event) begin
            w_push = 1'b1;
            if (WRAP_MODE == 0 && w_count == CW'(DEPTH - 1) && !w_pop) w_state_d = ST_DONE;
          end
        end
        ST_DONE: w_drop_ovf = w_event;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ts        <= '0;
      r_triggered <= 1'b0;
      r_overflow  <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (i_arm) begin
        r_ts        <= '0;
        r_triggered <= 1'b0;
        r_overflow  <= 1'b0;
        r_collision <= 1'b0;
      end else begin
        r_ts        <= r_ts + TS_W'(1);
        r_triggered <= r_triggered | w_set_trig;
        r_overflow  <= r_overflow | w_drop_ovf | w_ovw;
        r_collision <= r_collision | (w_collision & w_busy);
      end
    end
  end

  trace_fifo #(
    .WIDTH     (REC_W),
    .DEPTH     (DEPTH),
    .WRAP_MODE (WRAP_MODE)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (i_arm),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_wdata     (w_rec),
    .o_rdata     (o_rd_data),
    .o_rvalid    (o_rd_valid),
    .o_count     (w_count),
    .o_empty     (o_empty),
    .o_full      (o_full),
    .o_overwrite (w_ovw)
  );

  assign o_count     = w_count;
  assign o_triggered = r_triggered;
  assign o_overflow  = r_overflow;
  assign o_collision = r_collision;
  assign o_busy      = w_busy;

endmodule

// File: tb/tb_bus_trace.sv
// Directed bench for bus_trace: a stop-on-full and a wrap-mode instance
// (DEPTH=4) driven by the same bus stimulus.
module tb_bus_trace;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  strb_n = 5'h1f;
  logic [19:0] addr = '0;
  logic [7:0]  rdata = '0, wdata = '0;
  logic        arm = 1'b0, trig_en = 1'b0, rd_en = 1'b0;
  logic [19:0] trig_addr = '0, trig_mask = '0;

  logic [46:0] s_rd_data, w_rd_data;
  logic [2:0]  s_count, w_count;
  logic        s_rd_valid, s_empty, s_full, s_trig, s_ovf, s_coll, s_busy;
  logic        w_rd_valid, w_empty, w_full, w_trig, w_ovf, w_coll, w_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_trace #(.ADDR_W(20), .DATA_W(8), .DEPTH(4), .TS_W(16), .WRAP_MODE(0)) u_stop (
    .i_clk(clk), .i_rst(rst), .i_mrdc_n(strb_n[0]), .i_mwtc_n(strb_n[1]),
    .i_iorc_n(strb_n[2]), .i_iowc_n(strb_n[3]), .i_inta_n(strb_n[4]),
    .i_addr(addr), .i_rdata(rdata), .i_wdata(wdata), .i_arm(arm), .i_trig_en(trig_en),
    .i_trig_addr(trig_addr), .i_trig_mask(trig_mask), .i_rd_en(rd_en),
    .o_rd_data(s_rd_data), .o_rd_valid(s_rd_valid), .o_empty(s_empty), .o_full(s_full),
    .o_count(s_count), .o_triggered(s_trig), .o_overflow(s_ovf), .o_collision(s_coll),
    .o_busy(s_busy)
  );

  bus_trace #(.ADDR_W(20), .DATA_W(8), .DEPTH(4), .TS_W(16), .WRAP_MODE(1)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_mrdc_n(strb_n[0]), .i_mwtc_n(strb_n[1]),
    .i_iorc_n(strb_n[2]), .i_iowc_n(strb_n[3]), .i_inta_n(strb_n[4]),
    .i_addr(addr), .i_rdata(rdata), .i_wdata(wdata), .i_arm(arm), .i_trig_en(trig_en),
    .i_trig_addr(trig_addr), .i_trig_mask(trig_mask), .i_rd_en(rd_en),
    .o_rd_data(w_rd_data), .o_rd_valid(w_rd_valid), .o_empty(w_empty), .o_full(w_full),
    .o_count(w_count), .o_triggered(w_trig), .o_overflow(w_ovf), .o_collision(w_coll),
    .o_busy(w_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [46:0] rec(input logic [2:0] t, input logic [19:0] a,
                                      input logic [7:0] d, input logic [15:0] ts);
    return {t, a, d, ts};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic te);
    trig_en = te;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // One bus cycle: strobes in lo held low for one cycle, then released; the
  // bus is scrambled on release so only the registered copies can be recorded.
  task automatic cyc(input logic [4:0] lo, input logic [19:0] a, input logic [7:0] rd,
                     input logic [7:0] wd, input logic pop_at_end);
    strb_n = ~lo;
    addr   = a;
    rdata  = rd;
    wdata  = wd;
    tick();
    strb_n = 5'h1f;
    addr   = 20'hABCDE;
    rdata  = 8'hCC;
    wdata  = 8'h33;
    rd_en  = pop_at_end;
    tick();
    rd_en  = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_empty", s_empty, 1);
    chk("rst_count", s_count, 0);
    chk("rst_full", w_full, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_rd_valid", w_rd_valid, 0);
    chk("rst_rd_data", s_rd_data, 0);
    chk("rst_flags", {s_trig, s_ovf, s_coll, w_trig, w_ovf, w_coll}, 0);

    // Plain capture: write then read of 0x00100.
    do_arm(1'b0);
    chk("cap_busy", s_busy, 1);
    cyc(5'b00010, 20'h00100, 8'h00, 8'hA5, 1'b0);
    cyc(5'b00001, 20'h00100, 8'hA5, 8'h00, 1'b0);
    chk("cap_count", s_count, 2);
    pop();
    chk("cap_valid1", s_rd_valid, 1);
    chk("cap_rec1", s_rd_data, rec(3'd1, 20'h00100, 8'hA5, 16'd1));
    pop();
    chk("cap_rec2", s_rd_data, rec(3'd0, 20'h00100, 8'hA5, 16'd3));
    chk("cap_empty", s_empty, 1);
    pop();
    chk("cap_pop_empty_valid", s_rd_valid, 0);
    chk("cap_pop_empty_hold", s_rd_data, rec(3'd0, 20'h00100, 8'hA5, 16'd3));

    // Address trigger on 0x0004x.
    trig_addr = 20'h00040;
    trig_mask = 20'hFFFF0;
    do_arm(1'b1);
    chk("trg_busy", w_busy, 1);
    cyc(5'b00100, 20'h0003F, 8'h11, 8'h00, 1'b0);
    chk("trg_not_yet", {s_trig, s_count}, 0);
    cyc(5'b01000, 20'h00042, 8'h00, 8'h5A, 1'b0);
    chk("trg_triggered", s_trig, 1);
    chk("trg_count", s_count, 1);
    pop();
    chk("trg_rec", s_rd_data, rec(3'd3, 20'h00042, 8'h5A, 16'd3));
    trig_en = 1'b0;

    // Six writes into a 4-deep buffer.
    do_arm(1'b0);
    for (int i = 1; i <= 6; i++) cyc(5'b00010, 20'(i), 8'h00, 8'(16 + i), 1'b0);
    chk("stop_count", s_count, 4);
    chk("stop_full", s_full, 1);
    chk("stop_busy_done", s_busy, 0);
    chk("stop_ovf", s_ovf, 1);
    chk("wrap_count", w_count, 4);
    chk("wrap_ovf", w_ovf, 1);
    chk("wrap_busy", w_busy, 1);
    for (int i = 0; i < 4; i++) begin
      pop();
      chk("stop_pop", s_rd_data, rec(3'd1, 20'(i + 1), 8'(17 + i), 16'(2 * i + 1)));
      chk("wrap_pop", w_rd_data, rec(3'd1, 20'(i + 3), 8'(19 + i), 16'(2 * i + 5)));
    end
    chk("wrap_empty_after", w_empty, 1);

    // Simultaneous IOWR+MEMRD, then push+pop while full.
    do_arm(1'b0);
    cyc(5'b01001, 20'h00200, 8'h88, 8'h77, 1'b0);
    chk("coll_flag", s_coll, 1);
    chk("coll_count", w_count, 1);
    for (int i = 1; i <= 3; i++) cyc(5'b00001, 20'h00300 + 20'(i), 8'(8'h80 + i), 8'h00, 1'b0);
    chk("coll_full", {s_full, w_full}, 2'b11);
    cyc(5'b00010, 20'h00400, 8'h00, 8'hEE, 1'b1);
    chk("pp_valid", w_rd_valid, 1);
    chk("pp_wrap_oldest", w_rd_data, rec(3'd3, 20'h00200, 8'h77, 16'd1));
    chk("pp_stop_oldest", s_rd_data, rec(3'd3, 20'h00200, 8'h77, 16'd1));
    chk("pp_wrap_count", w_count, 4);
    chk("pp_wrap_ovf", w_ovf, 0);
    chk("pp_stop_count", s_count, 3);
    chk("pp_stop_ovf", s_ovf, 1);
    pop();
    chk("pp_wrap_next", w_rd_data, rec(3'd0, 20'h00301, 8'h81, 16'd3));
    pop();
    pop();
    pop();
    chk("pp_wrap_last", w_rd_data, rec(3'd1, 20'h00400, 8'hEE, 16'd9));
    chk("pp_stop_last", s_rd_data, rec(3'd0, 20'h00303, 8'h83, 16'd7));

    // Reset mid-session clears everything.
    do_arm(1'b1);
    cyc(5'b00001, 20'h00041, 8'h01, 8'h00, 1'b0);
    cyc(5'b00110, 20'h00042, 8'h02, 8'h03, 1'b0);
    cyc(5'b00001, 20'h00043, 8'h04, 8'h00, 1'b0);
    chk("pre_rst_state", {s_trig, s_coll, s_count}, {1'b1, 1'b1, 3'd3});
    trig_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_empty", {s_empty, w_empty}, 2'b11);
    chk("mid_rst_count", w_count, 0);
    chk("mid_rst_flags", {s_trig, s_ovf, s_coll, w_trig, w_ovf, w_coll, s_busy}, 0);

    // arm coincident with an event drops the event.
    do_arm(1'b0);
    strb_n = 5'b11110;
    addr   = 20'h00500;
    rdata  = 8'h55;
    tick();
    strb_n = 5'h1f;
    arm    = 1'b1;
    tick();
    arm    = 1'b0;
    chk("arm_evt_count", s_count, 0);
    chk("arm_evt_busy", s_busy, 1);
    cyc(5'b00001, 20'h00600, 8'h66, 8'h00, 1'b0);
    pop();
    chk("arm_evt_next", s_rd_data, rec(3'd0, 20'h00600, 8'h66, 16'd1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_trace.md
# bus_trace

Parametrised on-chip bus cycle tracer for the 8088 system. It sits beside `mpe` and snoops the command strobes (MRDC/MWTC/IORC/IOWC/INTA), the address bus and the data buses. Each completed bus cycle is recorded with a timestamp into a DEPTH-entry trace buffer, with an optional address trigger and either stop-on-full or wrap-around mode. Its purpose is to replace waveform eyeballing in the system bench, and it also synthesises for on-board debug.

## Interface
- ADDR_W, 20, address bus width
- DATA_W, 8, data bus width
- DEPTH, 64, trace entries; power of two, ≥4
- TS_W, 16, timestamp width
- WRAP_MODE, 0, 0 = stop when full, 1 = overwrite oldest
- REC_W (localparam) = 3+ADDR_W+DATA_W+TS_W, 47 at defaults
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mrdc_n, mwtc_n, iorc_n, iowc_n, inta_n  in  1 each  active-low command strobes, synchronous to clk
- addr  in  ADDR_W  CPU address
- rdata  in  DATA_W  read data returned to the CPU (RAM/ROM/IO mux)
- wdata  in  DATA_W  CPU write data
- arm  in  1  one-cycle pulse; clears the buffer and starts a capture session
- trig_en  in  1  sampled on arm; 1 = wait for the trigger before recording
- trig_addr, trig_mask  in  ADDR_W  trigger fires when (addr & trig_mask) == (trig_addr & trig_mask)
- rd_en  in  1  pop the oldest record
- rd_data  out  REC_W  {type[2:0], addr, data, ts}; reset 0
- rd_valid  out  1  rd_data valid pulse; reset 0
- empty  out  1  reset 1
- full  out  1  reset 0
- count  out  $clog2(DEPTH)+1  entries held; reset 0
- triggered  out  1  sticky; reset 0
- overflow  out  1  sticky; reset 0
- collision  out  1  sticky; reset 0
- busy  out  1  1 in ARMED or CAPTURE; reset 0

## Operation
- Record type codes: 0 MEMRD, 1 MEMWR, 2 IORD, 3 IOWR, 4 INTA.
- Event: a strobe seen low last cycle and high this cycle (trailing edge).
  - The record takes addr and data (rdata for reads/INTA, wdata for writes) from the last cycle the strobe was low, using registered copies.
  - ts is taken at the event cycle.
- If two or more strobes end in the same cycle, one record is written. Priority: INTA > IOWR > IORD > MEMWR > MEMRD. collision is set.
- ts is a free-running TS_W counter, cleared by arm and by rst, and wraps modulo 2^TS_W.
- FSM:
  - IDLE (reset state): no recording.
  - arm (honoured in any state): FIFO, ts and sticky flags are cleared. Next state is ARMED if trig_en, else CAPTURE.
  - ARMED: events are discarded until one matches the trigger. That event is recorded, triggered is set, and the FSM goes to CAPTURE.
  - CAPTURE: every event is recorded.
  - WRAP_MODE=0: the push that makes count==DEPTH moves the FSM to DONE. Events in DONE set overflow and are dropped.
  - WRAP_MODE=1: the FSM stays in CAPTURE. A push when full overwrites the oldest entry (read pointer advances), count is unchanged, and overflow is set.
  - DONE: no recording; leaves only on arm or rst.
- Readout is allowed in every state. rd_en while empty is ignored (no rd_valid).
- Push and pop in the same cycle: the pop returns the oldest entry, the push is written, and count is unchanged. This applies even when full, and in that case no overwrite and no overflow occur.
- arm in the same cycle as an event: arm wins and the event is dropped. arm in the same cycle as rd_en: the pop is dropped.
- rst mid-session returns everything to the reset values. Memory contents are don't-care.

## Timing
- Event detected in cycle t. Entry written, and count/empty/full updated, at the edge ending cycle t. The FSM transition takes effect at the same edge.
- rd_en high at edge k: rd_data and rd_valid are valid in cycle k+1. rd_valid is a one-cycle pulse. rd_data holds its value until the next pop.
- Back-to-back rd_en gives one record per cycle.
- count, empty, full and busy are registered.
- There is no combinational path from inputs to outputs.
- Minimum strobe low time is 1 cycle. Strobe low for 0 cycles (a glitch between samples) is not seen.

## Structure
- Package `mpe_trace_pkg` holds:
  - record type codes TR_MEMRD..TR_INTA
  - FSM state encodings ST_IDLE/ST_ARMED/ST_CAPTURE/ST_DONE
  - the REC_W function
- One sub-module, `trace_fifo` (params WIDTH, DEPTH, WRAP_MODE):
  - synchronous-read RAM with rd/wr pointers and count, overwrite-on-full when WRAP_MODE
  - push, pop, clear inputs
- Top level holds the strobe edge detect, the input registers, the priority encoder, the trigger compare, the ts counter and the FSM.

## Test plan
- No trigger, capture mode: arm; MEMWR 0x00100 wdata 0xA5, then MEMRD 0x00100 rdata 0xA5 → count=2, pops give type 1/addr 0x00100/data 0xA5 then type 0/data 0xA5, ts strictly increasing.
- Trigger: trig_en=1, trig_addr=0x00040, mask=0xFFFF0; IORD at 0x0003F then IOWR at 0x00042 → only the IOWR is recorded, triggered=1, count=1.
- Stop on full: WRAP_MODE=0, DEPTH=4, 6 events → count=4, full=1, FSM in DONE, busy=0, overflow=1, pops return events 1–4.
- Wrap: WRAP_MODE=1, DEPTH=4, 6 events → count=4, overflow=1, pops return events 3–6 in order.
- Collision and simultaneity: iowc_n and mrdc_n rise in the same cycle → one type-3 record, collision=1. Then push+pop while full → count unchanged, oldest entry returned, overflow stays 0.
- Reset/arm mid-session: rst after 3 events → empty=1, count=0, all flags 0. arm coincident with an event → event dropped, count=0.
